bit_stuffer: RTL and testbench

- USB transmit bit stuffer. It sits directly upstream of the NRZI encoder, between the packet serializer/CRC stage and NRZI.
- After six consecutive 1s it inserts a 0 and stalls the upstream bit source for that cycle.
- It passes the packet-type qualifier through alongside each output bit.
- The output pair bstr_out/bstr_out_ready drives the NRZI stage's bstr_in/bstr_in_ready directly.

---
 rtl/bit_stuffer.sv | 74 +++++++
 tb/tb_bit_stuffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after RUN_LEN consecutive 1s within a packet and stalls upstream meanwhile.
// Optional BITSTUFF_TAIL_EN: also emit the stuff 0 when a packet ends or changes type right after a full run.
module bit_stuffer #(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bstr_in,
    input  logic [1:0]       bstr_in_ready,
    output logic             bstr_in_pause,
    output logic             bstr_out,
    output logic [1:0]       bstr_out_ready,
    output logic [CNT_W-1:0] stuff_cnt
);

    localparam logic [2:0] RUN = 3'(RUN_LEN);

    logic [2:0] ones_cnt;
    logic [1:0] cur_type;
    logic       in_valid;
    logic       same_pkt;
    logic       at_run;
    logic       stuff;

    always_comb begin
        in_valid = |bstr_in_ready;
        same_pkt = (bstr_in_ready == cur_type);
        at_run   = (ones_cnt == RUN);
`ifdef BITSTUFF_TAIL_EN
        // A full run always gets its 0, even when the packet is over; a waiting new packet is held off.
        stuff         = at_run;
        bstr_in_pause = at_run && in_valid;
`else
        stuff         = at_run && in_valid && same_pkt;
        bstr_in_pause = stuff;
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bstr_out       <= 1'b0;
            bstr_out_ready <= 2'b00;
            stuff_cnt      <= '0;
            ones_cnt       <= '0;
            cur_type       <= 2'b00;
        end else if (stuff) begin
            bstr_out       <= 1'b0;
            bstr_out_ready <= cur_type;
            ones_cnt       <= '0;
            if (!(&stuff_cnt))
                stuff_cnt <= stuff_cnt + 1'b1;
            // Tail stuff closes the packet so whatever follows is seen as a new one.
            if (!(in_valid && same_pkt))
                cur_type <= 2'b00;
        end else if (in_valid) begin
            bstr_out       <= bstr_in;
            bstr_out_ready <= bstr_in_ready;
            cur_type       <= bstr_in_ready;
            if (!same_pkt) begin
                ones_cnt  <= bstr_in ? 3'd1 : 3'd0;
                stuff_cnt <= '0;
            end else begin
                ones_cnt <= bstr_in ? ones_cnt + 3'd1 : 3'd0;
            end
        end else begin
            bstr_out       <= 1'b0;
            bstr_out_ready <= 2'b00;
            ones_cnt       <= '0;
            cur_type       <= 2'b00;
        end
    end

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed scoreboard bench for bit_stuffer: expected output bits are queued as stimulus is driven.
module tb_bit_stuffer;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       bstr_in = 1'b0;
    logic [1:0] bstr_in_ready = 2'b00;
    logic       bstr_in_pause;
    logic       bstr_out;
    logic [1:0] bstr_out_ready;
    logic [3:0] stuff_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int pause_cnt = 0;
    int pause_at = -1;
    int idx = 0;
    logic [2:0] exp_q[$];

    bit_stuffer #(.RUN_LEN(6), .CNT_W(4)) dut (
        .clk(clk), .rst_b(rst_b), .bstr_in(bstr_in), .bstr_in_ready(bstr_in_ready),
        .bstr_in_pause(bstr_in_pause), .bstr_out(bstr_out), .bstr_out_ready(bstr_out_ready),
        .stuff_cnt(stuff_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every non-idle output bit must match the next queued {bit, type}.
    always @(negedge clk) begin
        if (rst_b && bstr_out_ready != 2'b00) begin
            logic [2:0] e;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: got %b/%b want nothing queued", bstr_out, bstr_out_ready);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                assert ({bstr_out, bstr_out_ready} === e) else begin
                    n_fail++;
                    $error("FAIL stream: got %b want %b", {bstr_out, bstr_out_ready}, e);
                end
            end
        end
    end

    task automatic push(input logic b, input logic [1:0] t);
        exp_q.push_back({b, t});
    endtask

    task automatic send(input logic b, input logic [1:0] t);
        int guard;
        guard = 0;
        bstr_in = b;
        bstr_in_ready = t;
        @(negedge clk);
        while (bstr_in_pause && guard < 4) begin
            pause_cnt++;
            pause_at = idx;
            guard++;
            @(negedge clk);
        end
        if (guard >= 4) chk("pause_timeout", guard, 0);
        @(posedge clk);
        #1;
        idx++;
    endtask

    task automatic send_push(input logic b, input logic [1:0] t);
        push(b, t);
        send(b, t);
    endtask

    task automatic idle(input int n);
        bstr_in = 1'b0;
        bstr_in_ready = 2'b00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_test();
        pause_cnt = 0;
        pause_at = -1;
        idx = 0;
    endtask

    initial begin
        logic [7:0] sync;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", bstr_out, 0);
        chk("rst_ready", bstr_out_ready, 0);
        chk("rst_pause", bstr_in_pause, 0);
        chk("rst_cnt", stuff_cnt, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        idle(2);

        // Token: sync + alternating 10, passes through untouched
        start_test();
        sync = 8'b0000_0001;
        for (int i = 7; i >= 0; i--) send_push(sync[i], 2'b01);
        for (int i = 0; i < 16; i++) send_push((i % 2) == 0, 2'b01);
        idle(3);
        chk("tok_pauses", pause_cnt, 0);
        chk("tok_cnt", stuff_cnt, 0);
        chk("tok_drain", exp_q.size(), 0);

        // Data: 8 ones then 0 -> 1111110 110
        start_test();
        for (int i = 0; i < 6; i++) push(1'b1, 2'b10);
        push(1'b0, 2'b10);
        push(1'b1, 2'b10); push(1'b1, 2'b10); push(1'b0, 2'b10);
        for (int i = 0; i < 8; i++) send(1'b1, 2'b10);
        send(1'b0, 2'b10);
        idle(3);
        chk("d8_pauses", pause_cnt, 1);
        chk("d8_pause_at", pause_at, 6);
        chk("d8_cnt", stuff_cnt, 1);
        chk("d8_drain", exp_q.size(), 0);

        // Data: 12 ones then 0 -> 0s inserted after output bits 6 and 13
        start_test();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) push(1'b1, 2'b10);
            push(1'b0, 2'b10);
        end
        push(1'b0, 2'b10);
        for (int i = 0; i < 12; i++) send(1'b1, 2'b10);
        send(1'b0, 2'b10);
        idle(3);
        chk("d12_pauses", pause_cnt, 2);
        chk("d12_cnt", stuff_cnt, 2);
        chk("d12_drain", exp_q.size(), 0);

        // Handshake ending on exactly six ones
        start_test();
        for (int i = 0; i < 6; i++) send_push(1'b1, 2'b11);
`ifdef BITSTUFF_TAIL_EN
        push(1'b0, 2'b11);
`endif
        idle(1);
        @(negedge clk);
`ifdef BITSTUFF_TAIL_EN
        chk("hs_tail_ready", bstr_out_ready, 3);
`else
        chk("hs_tail_ready", bstr_out_ready, 0);
`endif
        @(posedge clk);
        #1;
        idle(2);
`ifdef BITSTUFF_TAIL_EN
        chk("hs_cnt", stuff_cnt, 1);
`else
        chk("hs_cnt", stuff_cnt, 0);
`endif
        chk("hs_drain", exp_q.size(), 0);

        // Back-to-back: handshake 0111 straight into token 11111, run restarts
        start_test();
        send_push(1'b0, 2'b11);
        for (int i = 0; i < 3; i++) send_push(1'b1, 2'b11);
        for (int i = 0; i < 5; i++) send_push(1'b1, 2'b01);
        chk("b2b_cnt", stuff_cnt, 0);
        idle(3);
        chk("b2b_pauses", pause_cnt, 0);
        chk("b2b_drain", exp_q.size(), 0);

        // Async reset while a stuff is pending
        start_test();
        for (int i = 0; i < 6; i++) send_push(1'b1, 2'b10);
        @(negedge clk);
        #1;
        chk("pre_rst_pause", bstr_in_pause, 1);
        rst_b = 1'b0;
        #1;
        chk("arst_pause", bstr_in_pause, 0);
        chk("arst_out", bstr_out, 0);
        chk("arst_ready", bstr_out_ready, 0);
        chk("arst_cnt", stuff_cnt, 0);
        chk("arst_drain", exp_q.size(), 0);
        bstr_in_ready = 2'b00;
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        idle(1);
        start_test();
        for (int i = 0; i < 6; i++) push(1'b1, 2'b10);
        push(1'b0, 2'b10); push(1'b1, 2'b10); push(1'b0, 2'b10);
        for (int i = 0; i < 7; i++) send(1'b1, 2'b10);
        send(1'b0, 2'b10);
        idle(3);
        chk("post_rst_pauses", pause_cnt, 1);
        chk("post_rst_pause_at", pause_at, 6);
        chk("post_rst_cnt", stuff_cnt, 1);
        chk("post_rst_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
